// File: rtl/nrs_pkg.sv
// Shared state encoding, default parameter constants and index-width helper
// for the NR sequence generator controller.
package nrs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ_CINIT = 3'd1,
    ST_SEED      = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_EVAL      = 3'd4
  } nrs_state_e;

  localparam int NC_DEF          = 1600;
  localparam int LFSR_W_DEF      = 31;
  localparam int EVAL_CYCLES_DEF = 4;
  localparam int RUNS_DEF        = 2;
  localparam int NUM_PORTS_DEF   = 2;
  localparam int DEPTH_DEF       = 16;

  // Width of an index over n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nrs_phase_counter.sv
// Cycle counter for the SHIFT and EVAL phases. Flags the last cycle of
// each phase so the controller can advance on the following edge.
module nrs_phase_counter #(
  parameter int SHIFT_LEN = 1570,
  parameter int EVAL_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_active,
  input  logic eval_active,
  output logic shift_done,
  output logic eval_done
);

  localparam int MAX_LEN = (SHIFT_LEN > EVAL_LEN) ? SHIFT_LEN : EVAL_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign shift_done = shift_active && (cnt_q == CW'(SHIFT_LEN - 1));
  assign eval_done  = eval_active  && (cnt_q == CW'(EVAL_LEN - 1));

  // Count within a phase; restart at every phase boundary or abort.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || !(shift_active || eval_active) || shift_done || eval_done) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nrs_ctrl_multiport.sv
// Controller sequencing Gold-sequence runs per antenna port into a
// double-banked output buffer: seed request, LFSR load, NC warm-up shift,
// word evaluation, and bank hand-off to the downstream consumer.
module nrs_ctrl_multiport
  import nrs_pkg::*;
#(
  parameter int NC          = NC_DEF,
  parameter int LFSR_W      = LFSR_W_DEF,
  parameter int EVAL_CYCLES = EVAL_CYCLES_DEF,
  parameter int RUNS        = RUNS_DEF,
  parameter int NUM_PORTS   = NUM_PORTS_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          new_frame,
  input  logic                          new_subframe,
  input  logic                          cinit_valid,
  input  logic [1:0]                    est_ack,
  output logic                          cinit_req,
  output logic                          init_x1,
  output logic                          init_x2,
  output logic                          shift_x,
  output logic                          out_en,
  output logic                          wr_en,
  output logic                          wr_bank,
  output logic                          busy,
  output logic                          overrun,
  output logic [idx_w(NUM_PORTS)-1:0]   port_idx,
  output logic [idx_w(RUNS)-1:0]        run_idx,
  output logic [$clog2(DEPTH)-1:0]      wr_addr,
  output logic [1:0]                    bank_ready
);

  localparam int PW        = idx_w(NUM_PORTS);
  localparam int RW        = idx_w(RUNS);
  localparam int AW        = $clog2(DEPTH);
  localparam int SHIFT_LEN = NC - LFSR_W + 1;

  nrs_state_e    state_q, state_d;
  logic [PW-1:0] port_q, port_d;
  logic [RW-1:0] run_q, run_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          bank_q, bank_d;
  logic [1:0]    ready_q, ready_d;
  logic          x1_arm_q, x1_arm_d;
  logic          overrun_q, overrun_d;

  logic          abort;
  logic          shift_done;
  logic          eval_done;
  logic          last_run;
  logic [1:0]    set_mask;

  // A new frame while active restarts the subframe from its first run.
  assign abort    = new_frame && (state_q != ST_IDLE);
  assign last_run = (port_q == PW'(NUM_PORTS - 1)) && (run_q == RW'(RUNS - 1));

  nrs_phase_counter #(
    .SHIFT_LEN (SHIFT_LEN),
    .EVAL_LEN  (EVAL_CYCLES)
  ) u_phase (
    .clk          (clk),
    .rst          (rst),
    .clr          (abort),
    .shift_active (state_q == ST_SHIFT),
    .eval_active  (state_q == ST_EVAL),
    .shift_done   (shift_done),
    .eval_done    (eval_done)
  );

  // Next-state, run indexing, address and bank bookkeeping.
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    run_d     = run_q;
    addr_d    = addr_q;
    bank_d    = bank_q;
    x1_arm_d  = x1_arm_q;
    overrun_d = 1'b0;
    set_mask  = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (new_frame || new_subframe) begin
          if (!ready_q[bank_q]) begin
            state_d = ST_REQ_CINIT;
            port_d  = '0;
            run_d   = '0;
            addr_d  = '0;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      ST_REQ_CINIT: begin
        if (cinit_valid) begin
          state_d = ST_SEED;
        end
      end
      ST_SEED: begin
        state_d  = ST_SHIFT;
        x1_arm_d = 1'b0;
      end
      ST_SHIFT: begin
        if (shift_done) begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        addr_d = addr_q + AW'(1);
        if (eval_done) begin
          if (last_run) begin
            set_mask = bank_q ? 2'b10 : 2'b01;
            bank_d   = ~bank_q;
            state_d  = ST_IDLE;
            port_d   = '0;
            run_d    = '0;
            addr_d   = '0;
          end else begin
            state_d = ST_REQ_CINIT;
            if (run_q == RW'(RUNS - 1)) begin
              run_d  = '0;
              port_d = port_q + PW'(1);
            end else begin
              run_d = run_q + RW'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every frame boundary restarts the x1 sequence at the next seed.
    if (new_frame) begin
      x1_arm_d = 1'b1;
    end

    if (abort) begin
      state_d   = ST_REQ_CINIT;
      port_d    = '0;
      run_d     = '0;
      addr_d    = '0;
      bank_d    = bank_q;
      set_mask  = 2'b00;
      overrun_d = 1'b0;
    end else if (new_subframe && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    // Completion set takes precedence over a same-cycle consumer release.
    ready_d = (ready_q & ~est_ack) | set_mask;
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      port_q    <= '0;
      run_q     <= '0;
      addr_q    <= '0;
      bank_q    <= 1'b0;
      ready_q   <= 2'b00;
      x1_arm_q  <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      run_q     <= run_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      ready_q   <= ready_d;
      x1_arm_q  <= x1_arm_d;
      overrun_q <= overrun_d;
    end
  end

  assign cinit_req  = (state_q == ST_REQ_CINIT);
  assign init_x2    = (state_q == ST_SEED);
  assign init_x1    = (state_q == ST_SEED) && x1_arm_q;
  assign shift_x    = (state_q == ST_SHIFT) || (state_q == ST_EVAL);
  assign out_en     = (state_q == ST_EVAL);
  assign wr_en      = (state_q == ST_EVAL);
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = overrun_q;
  assign wr_bank    = bank_q;
  assign bank_ready = ready_q;
  assign port_idx   = port_q;
  assign run_idx    = run_q;
  assign wr_addr    = addr_q;

endmodule

// File: tb/tb_nrs_ctrl_multiport.sv
// Directed bench for nrs_ctrl_multiport: a default two-port instance and a
// single-port/single-run instance, with seed and word scoreboards.
module tb_nrs_ctrl_multiport;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       new_frame = 0, new_subframe = 0, cinit_valid = 0;
  logic [1:0] est_ack = 2'b00;
  logic       cinit_req, init_x1, init_x2, shift_x, out_en, wr_en, wr_bank, busy, overrun;
  logic [0:0] port_idx, run_idx;
  logic [3:0] wr_addr;
  logic [1:0] bank_ready;

  // Single-port instance
  logic       new_frame_s = 0, new_subframe_s = 0, cinit_valid_s = 0;
  logic [1:0] est_ack_s = 2'b00;
  logic       cinit_req_s, init_x1_s, init_x2_s, shift_x_s, out_en_s, wr_en_s, wr_bank_s, busy_s, overrun_s;
  logic [0:0] port_idx_s, run_idx_s;
  logic [3:0] wr_addr_s;
  logic [1:0] bank_ready_s;

  nrs_ctrl_multiport dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .new_subframe(new_subframe),
    .cinit_valid(cinit_valid), .est_ack(est_ack), .cinit_req(cinit_req),
    .init_x1(init_x1), .init_x2(init_x2), .shift_x(shift_x), .out_en(out_en),
    .wr_en(wr_en), .wr_bank(wr_bank), .busy(busy), .overrun(overrun),
    .port_idx(port_idx), .run_idx(run_idx), .wr_addr(wr_addr), .bank_ready(bank_ready)
  );

  nrs_ctrl_multiport #(.EVAL_CYCLES(8), .RUNS(1), .NUM_PORTS(1)) dut_s (
    .clk(clk), .rst(rst), .new_frame(new_frame_s), .new_subframe(new_subframe_s),
    .cinit_valid(cinit_valid_s), .est_ack(est_ack_s), .cinit_req(cinit_req_s),
    .init_x1(init_x1_s), .init_x2(init_x2_s), .shift_x(shift_x_s), .out_en(out_en_s),
    .wr_en(wr_en_s), .wr_bank(wr_bank_s), .busy(busy_s), .overrun(overrun_s),
    .port_idx(port_idx_s), .run_idx(run_idx_s), .wr_addr(wr_addr_s), .bank_ready(bank_ready_s)
  );

  typedef struct packed {
    logic       bank;
    logic       port;
    logic       run;
    logic [3:0] addr;
  } wr_t;

  wr_t        exp_q[$];
  bit         x1_q[$];
  logic [3:0] exp2_q[$];
  wr_t        mon_e;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word and seed monitor for the default instance
  int   shift_cnt = 0;
  logic prev_oe = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      shift_cnt = 0;
      prev_oe   = 1'b0;
    end else begin
      if (init_x2) begin
        shift_cnt = 0;
        if (x1_q.size() == 0) check("seed_unexpected", 1, 0);
        else check("init_x1", init_x1, x1_q.pop_front());
      end
      if (shift_x && !out_en) shift_cnt++;
      if (out_en) begin
        if (!prev_oe) check("shift_gap", shift_cnt, 1570);
        check("wr_en", wr_en, 1);
        if (exp_q.size() == 0) check("word_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", wr_addr, mon_e.addr);
          check("port_idx", port_idx, mon_e.port);
          check("run_idx", run_idx, mon_e.run);
          check("wr_bank", wr_bank, mon_e.bank);
        end
      end
      prev_oe = out_en;
    end
  end

  // Word monitor for the single-port instance
  always @(negedge clk) begin
    if (!rst && out_en_s) begin
      if (exp2_q.size() == 0) check("w2_unexpected", 1, 0);
      else check("w2_addr", wr_addr_s, exp2_q.pop_front());
      check("w2_port", port_idx_s, 0);
    end
  end

  task automatic push_sub(input bit bank, input bit x1first, input int nseeds, input int nword_runs);
    wr_t e;
    for (int r = 0; r < nseeds; r++) x1_q.push_back((r == 0) ? x1first : 1'b0);
    for (int r = 0; r < nword_runs; r++) begin
      for (int a = 0; a < 4; a++) begin
        e.bank = bank;
        e.port = r[1];
        e.run  = r[0];
        e.addr = 4'(r * 4 + a);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic strobe(input bit f, input bit s);
    @(negedge clk);
    new_frame = f;
    new_subframe = s;
    @(negedge clk);
    new_frame = 0;
    new_subframe = 0;
  endtask

  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = 0;
      while (!cinit_req && k < 4000) begin
        @(negedge clk);
        k++;
      end
      if (k >= 4000) check("cinit_req_timeout", 0, 1);
      else begin
        repeat (3) @(negedge clk);
        check("cinit_req_hold", cinit_req, 1);
        cinit_valid = 1;
        @(negedge clk);
        cinit_valid = 0;
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_word(input logic [3:0] a);
    int k;
    k = 0;
    while (!(out_en && wr_addr == a) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("word_wait_timeout", out_en, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_cinit_req", cinit_req, 0);
    check("rst_bank_ready", bank_ready, 2'b00);
    check("rst_wr_bank", wr_bank, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_overrun", overrun, 0);
    check("rst_out_en", out_en, 0);
    check("rst_shift_x", shift_x, 0);
    rst = 0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    // Subframe into bank 0 after new_frame
    push_sub(0, 1, 4, 4);
    strobe(1, 0);
    check("busy_after_frame", busy, 1);
    serve(4);
    wait_idle();
    check("sf1_bank_ready", bank_ready, 2'b01);
    check("sf1_wr_bank", wr_bank, 1);
    check("sf1_words_left", exp_q.size(), 0);
    check("sf1_seeds_left", x1_q.size(), 0);

    // Second subframe into bank 1 without release
    push_sub(1, 0, 4, 4);
    strobe(0, 1);
    serve(4);
    wait_idle();
    check("sf2_bank_ready", bank_ready, 2'b11);
    check("sf2_wr_bank", wr_bank, 0);

    // Third trigger with both banks full
    strobe(0, 1);
    check("ovr_pulse", overrun, 1);
    check("ovr_idle", busy, 0);
    @(negedge clk);
    check("ovr_clear", overrun, 0);
    check("ovr_still_idle", busy, 0);
    check("ovr_bank_ready", bank_ready, 2'b11);

    // Release both banks
    @(negedge clk); est_ack = 2'b11;
    @(negedge clk); est_ack = 2'b00;
    check("ack_both", bank_ready, 2'b00);

    // new_frame mid-SHIFT of the third run
    push_sub(0, 1, 3, 2);
    strobe(1, 0);
    serve(3);
    repeat (500) @(negedge clk);
    check("abort_in_shift", shift_x && !out_en, 1);
    strobe(1, 0);
    check("abort_busy", busy, 1);
    check("abort_cinit_req", cinit_req, 1);
    check("abort_wr_addr", wr_addr, 0);
    check("abort_bank_ready", bank_ready, 2'b00);
    check("abort_wr_bank", wr_bank, 0);
    check("abort_overrun", overrun, 0);
    check("abort_words_left", exp_q.size(), 0);
    push_sub(0, 1, 4, 4);
    serve(4);
    wait_idle();
    check("abort_done_ready", bank_ready, 2'b01);
    check("abort_done_bank", wr_bank, 1);

    // Release bank 0, fill bank 1
    @(negedge clk); est_ack = 2'b01;
    @(negedge clk); est_ack = 2'b00;
    check("ack_b0", bank_ready, 2'b00);
    push_sub(1, 0, 4, 4);
    strobe(0, 1);
    serve(4);
    wait_idle();
    check("sf_b1_ready", bank_ready, 2'b10);

    // Bank 0 completes on the same cycle its release arrives
    push_sub(0, 0, 4, 4);
    strobe(0, 1);
    serve(4);
    wait_word(4'd15);
    est_ack = 2'b01;
    @(negedge clk);
    est_ack = 2'b00;
    check("set_wins_ready", bank_ready, 2'b11);
    check("set_wins_idle", busy, 0);
    check("set_wins_bank", wr_bank, 1);
    @(negedge clk); est_ack = 2'b10;
    @(negedge clk); est_ack = 2'b00;
    check("ack_b1_only", bank_ready, 2'b01);

    // Asynchronous reset during EVAL
    push_sub(1, 0, 1, 1);
    strobe(0, 1);
    serve(1);
    wait_word(4'd1);
    #2 rst = 1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_en", out_en, 0);
    check("arst_wr_en", wr_en, 0);
    check("arst_shift_x", shift_x, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_bank_ready", bank_ready, 2'b00);
    check("arst_wr_bank", wr_bank, 0);
    check("arst_cinit_req", cinit_req, 0);
    check("arst_port", port_idx, 0);
    check("arst_run", run_idx, 0);
    exp_q.delete();
    x1_q.delete();
    @(negedge clk);
    rst = 0;

    // Single-port, single-run, eight-word instance
    for (int i = 0; i < 8; i++) exp2_q.push_back(4'(i));
    @(negedge clk); new_frame_s = 1;
    @(negedge clk); new_frame_s = 0;
    check("s_busy", busy_s, 1);
    repeat (3) @(negedge clk);
    check("s_cinit_req", cinit_req_s, 1);
    cinit_valid_s = 1;
    @(negedge clk);
    cinit_valid_s = 0;
    check("s_init_x2", init_x2_s, 1);
    check("s_init_x1", init_x1_s, 1);
    begin
      int k;
      k = 0;
      while (busy_s && k < 4000) begin
        @(negedge clk);
        k++;
      end
      check("s_idle_timeout", busy_s, 0);
    end
    check("s_words_left", exp2_q.size(), 0);
    check("s_bank_ready", bank_ready_s, 2'b01);
    check("s_wr_bank", wr_bank_s, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
